fu_issue_arbiter: RTL and testbench

- Shares one functional unit among NUM_RS reservation-station instances.
- Each cycle it takes the ready-entry requests from the stations and picks a winner round-robin. It returns a one-hot grant so the winning station retires that entry.
- The winner's operands go into a single-entry issue register that drives the FU through a valid/ready handshake.
- Sits between the reservation stations and the FU. It also handles mispredict flush of the in-flight issue slot.

---
 rtl/fu_issue_arbiter_pkg.sv | 27 ++
 rtl/fu_issue_arbiter_rr_priority_picker.sv | 35 +++
 rtl/fu_issue_arbiter.sv | 102 ++++++++++
 tb/tb_fu_issue_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fu_issue_arbiter_pkg.sv
// Shared widths and the issue-slot payload for the FU issue arbiter slice.
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif
`ifndef RS_SIZE
`define RS_SIZE 4
`endif

package fu_issue_arbiter_pkg;

    localparam int unsigned GPR_W          = `GPR_SIZE;
    localparam int unsigned ROB_IDX_W      = `ROB_IDX_SIZE;
    localparam int unsigned RS_ENTRIES     = `RS_SIZE;
    localparam int unsigned NUM_RS_DEFAULT = 4;
    localparam int unsigned BUSY_W         = 16;

    typedef struct packed {
        logic [GPR_W-1:0]     op1;
        logic [GPR_W-1:0]     op2;
        logic [ROB_IDX_W-1:0] dst_rob_index;
        logic                 set_nzcv;
    } fu_issue_t;

endpackage

// File: rtl/fu_issue_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_priority_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]                               req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]       ptr,
    output logic [N-1:0]                               grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]       winner,
    output logic                                       any
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    // Scan the upper segment [ptr, N-1] first, then fall back to [0, ptr-1].
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (PTR_W'(i) >= ptr)) begin
                grant[i] = 1'b1;
                winner   = PTR_W'(i);
                any      = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                grant[i] = 1'b1;
                winner   = PTR_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Round-robin arbiter sharing one FU among reservation stations via a single-entry issue register.
module fu_issue_arbiter
    import fu_issue_arbiter_pkg::*;
#(
    parameter int unsigned NUM_RS = NUM_RS_DEFAULT
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic [NUM_RS-1:0]             in_rs_req,
    input  logic [NUM_RS*GPR_W-1:0]       in_rs_op1_value,
    input  logic [NUM_RS*GPR_W-1:0]       in_rs_op2_value,
    input  logic [NUM_RS*ROB_IDX_W-1:0]   in_rs_dst_rob_index,
    input  logic [NUM_RS-1:0]             in_rs_set_nzcv,
    output logic [NUM_RS-1:0]             out_rs_grant,
    input  logic                          in_fu_ready,
    output logic                          out_fu_valid,
    output logic [GPR_W-1:0]              out_fu_op1,
    output logic [GPR_W-1:0]              out_fu_op2,
    output logic [ROB_IDX_W-1:0]          out_fu_dst_rob_index,
    output logic                          out_fu_set_nzcv,
    input  logic                          in_rob_is_mispred,
    output logic [BUSY_W-1:0]             out_busy_cycles
);

    localparam int unsigned PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  winner;
    logic [NUM_RS-1:0] pick_grant;
    logic              pick_any;
    logic              slot_free;
    logic              arb_en;
    logic              take;
    logic              valid_q;
    fu_issue_t         issue_q;
    fu_issue_t         sel;
    logic [BUSY_W-1:0] busy_q;

    rr_priority_picker #(
        .N (NUM_RS)
    ) u_picker (
        .req    (in_rs_req),
        .ptr    (ptr),
        .grant  (pick_grant),
        .winner (winner),
        .any    (pick_any)
    );

    // A consume and a new load may share a cycle, giving 1 op/cycle throughput.
    assign slot_free    = !valid_q || in_fu_ready;
    assign arb_en       = slot_free && !in_rob_is_mispred && !in_rst;
    assign take         = arb_en && pick_any;
    assign out_rs_grant = arb_en ? pick_grant : '0;

    // Winner's operand slice.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (winner == PTR_W'(i)) begin
                sel.op1           = in_rs_op1_value[i*GPR_W +: GPR_W];
                sel.op2           = in_rs_op2_value[i*GPR_W +: GPR_W];
                sel.dst_rob_index = in_rs_dst_rob_index[i*ROB_IDX_W +: ROB_IDX_W];
                sel.set_nzcv      = in_rs_set_nzcv[i];
            end
        end
    end

    // Issue register, RR pointer and stall counter; flush beats load beats drain.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            valid_q <= 1'b0;
            issue_q <= '0;
            ptr     <= '0;
            busy_q  <= '0;
        end else begin
            if (in_rob_is_mispred) begin
                valid_q <= 1'b0;
            end else if (take) begin
                valid_q <= 1'b1;
                issue_q <= sel;
            end else if (in_fu_ready) begin
                valid_q <= 1'b0;
            end

            if (take) begin
                ptr <= (winner == PTR_W'(NUM_RS - 1)) ? '0 : winner + PTR_W'(1);
            end

            if (valid_q && !in_fu_ready && !in_rob_is_mispred && (busy_q != {BUSY_W{1'b1}})) begin
                busy_q <= busy_q + BUSY_W'(1);
            end
        end
    end

    assign out_fu_valid         = valid_q;
    assign out_fu_op1           = issue_q.op1;
    assign out_fu_op2           = issue_q.op2;
    assign out_fu_dst_rob_index = issue_q.dst_rob_index;
    assign out_fu_set_nzcv      = issue_q.set_nzcv;
    assign out_busy_cycles      = busy_q;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Randomised scoreboard bench for fu_issue_arbiter against a queue-based reference model.
module tb_fu_issue_arbiter;
    import fu_issue_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned GW = GPR_W;
    localparam int unsigned RW = ROB_IDX_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*GW-1:0]   op1_flat;
    logic [N*GW-1:0]   op2_flat;
    logic [N*RW-1:0]   dst_flat;
    logic [N-1:0]      nz_flat;
    logic [N-1:0]      grant;
    logic              fu_ready;
    logic              fu_valid;
    logic [GW-1:0]     fu_op1;
    logic [GW-1:0]     fu_op2;
    logic [RW-1:0]     fu_dst;
    logic              fu_nz;
    logic              mispred;
    logic [15:0]       busy;

    fu_issue_arbiter #(.NUM_RS(N)) dut (
        .in_clk               (clk),
        .in_rst               (rst),
        .in_rs_req            (req),
        .in_rs_op1_value      (op1_flat),
        .in_rs_op2_value      (op2_flat),
        .in_rs_dst_rob_index  (dst_flat),
        .in_rs_set_nzcv       (nz_flat),
        .out_rs_grant         (grant),
        .in_fu_ready          (fu_ready),
        .out_fu_valid         (fu_valid),
        .out_fu_op1           (fu_op1),
        .out_fu_op2           (fu_op2),
        .out_fu_dst_rob_index (fu_dst),
        .out_fu_set_nzcv      (fu_nz),
        .in_rob_is_mispred    (mispred),
        .out_busy_cycles      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        bit           chk;
        bit           valid;
        int           busy;
    } exp_t;

    exp_t      exp_q[$];
    fu_issue_t cons_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int        m_ptr   = 0;
    bit        m_valid = 1'b0;
    fu_issue_t m_op    = '0;
    int        m_busy  = 0;
    bit        m_known = 1'b0;
    bit        force_dead = 1'b0;

    logic [GW-1:0] op1_a [N];
    logic [GW-1:0] op2_a [N];
    logic [RW-1:0] dst_a [N];
    logic          nz_a  [N];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [N-1:0] r, input bit rdy, input bit mis, input bit rs);
        exp_t         e;
        int           w;
        int           idx;
        logic [N-1:0] g;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            op1_a[i] = $urandom;
            op2_a[i] = $urandom;
            dst_a[i] = RW'($urandom);
            nz_a[i]  = 1'($urandom);
        end
        if (force_dead) op1_a[2] = 32'hDEAD;
        for (int i = 0; i < N; i++) begin
            op1_flat[i*GW +: GW] = op1_a[i];
            op2_flat[i*GW +: GW] = op2_a[i];
            dst_flat[i*RW +: RW] = dst_a[i];
            nz_flat[i]           = nz_a[i];
        end
        req      = r;
        fu_ready = rdy;
        mispred  = mis;
        rst      = rs;

        // Round-robin choice: first requester starting from the pointer, modulo N.
        w = -1;
        if (!rs && (!m_valid || rdy) && !mis) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && ((r >> idx) & N'(1)) != 0) w = idx;
            end
        end
        g = (w >= 0) ? (N'(1) << w) : '0;

        e.grant = g;
        e.chk   = m_known;
        e.valid = m_valid;
        e.busy  = m_busy;
        exp_q.push_back(e);

        if (rs) begin
            m_valid = 1'b0;
            m_op    = '0;
            m_ptr   = 0;
            m_busy  = 0;
            m_known = 1'b1;
        end else begin
            if (m_valid && rdy && !mis) cons_q.push_back(m_op);
            if (m_valid && !rdy && !mis && m_busy < 65535) m_busy++;
            if (mis) begin
                m_valid = 1'b0;
            end else if (w >= 0) begin
                m_valid = 1'b1;
                m_op.op1 = op1_a[w];
                m_op.op2 = op2_a[w];
                m_op.dst_rob_index = dst_a[w];
                m_op.set_nzcv = nz_a[w];
                m_ptr = (w + 1) % N;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle with scoreboard entries.
    initial begin : monitor
        exp_t      e;
        fu_issue_t cur;
        fu_issue_t prev;
        fu_issue_t want;
        bit        prev_hold;
        prev_hold = 1'b0;
        prev      = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cur.op1 = fu_op1;
                cur.op2 = fu_op2;
                cur.dst_rob_index = fu_dst;
                cur.set_nzcv = fu_nz;
                chk("grant", 128'(grant), 128'(e.grant));
                chk("grant_onehot0", 128'($countones(grant) <= 1), 128'(1));
                chk("grant_in_req", 128'((grant & ~req) == '0), 128'(1));
                if (e.chk) begin
                    chk("fu_valid", 128'(fu_valid), 128'(e.valid));
                    chk("busy_cycles", 128'(busy), 128'(e.busy));
                    if (prev_hold) chk("hold_stable", 128'(cur), 128'(prev));
                    if (fu_valid && fu_ready && !mispred && !rst) begin
                        if (cons_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL consume_unexpected: got op %0h expected none", cur);
                        end else begin
                            want = cons_q.pop_front();
                            chk("issued_op", 128'(cur), 128'(want));
                        end
                    end
                    prev_hold = fu_valid && !fu_ready && !mispred && !rst;
                end else begin
                    prev_hold = 1'b0;
                end
                prev = cur;
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; req = '0; fu_ready = 1'b1; mispred = 1'b0;
        op1_flat = '0; op2_flat = '0; dst_flat = '0; nz_flat = '0;

        cycle('0, 1'b1, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0, 1'b0);

        // All stations requesting, FU always ready
        repeat (6) cycle(4'b1111, 1'b1, 1'b0, 1'b0);

        // Stall with the station-2 op waiting behind station 0
        cycle('0, 1'b1, 1'b0, 1'b1);
        cycle(4'b0101, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(4'b0101, 1'b0, 1'b0, 1'b0);
        force_dead = 1'b1;
        cycle(4'b0101, 1'b1, 1'b0, 1'b0);
        force_dead = 1'b0;
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);

        // Flush of a held op
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);

        // Reset while an op is held
        cycle(4'b1000, 1'b0, 1'b0, 1'b0);
        cycle(4'b1000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);

        // Pointer wrap from 3 back to station 0
        cycle(4'b0100, 1'b1, 1'b0, 1'b0);
        cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        cycle(4'b0011, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            cycle(N'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 99) == 0));
        end
        cycle('0, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("queues_drained", 128'(exp_q.size() + cons_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
